spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
- Downstream consumer of SPI_Periphery. Runs in the system clock domain.
- Synchronises CS/SCK and counts received bits; captures the 16-bit command word from COPI_register once it is stable; decodes read/write into an 8-bit configuration register bank for the multi-phase buck controller (duty setpoint, phase enable, dead-time, etc.).
- Drives data_send for readback: pipelined, so the response appears in the next frame.

Parameters:
- NUM_REGS, 8, number of 8-bit config registers (1..63; address 0x3F reserved for status)
- SYNC_STAGES, 2, synchroniser depth for CS and SCK (>=2)
- FRAME_BITS, 16, command bits per frame (must equal SPI_Periphery LENGTH_RECIEVED)

Ports:
- clk  input  1  system clock; must be >= 4x SCK frequency
- rst_internal  input  1  reset; asynchronous, active-low (system reset, not CS-gated)
- spi_cs  input  1  raw SPI chip select, active low (async)
- spi_sck  input  1  raw SPI clock (async)
- copi_word  input  16  SPI_Periphery.COPI_register
- data_send  output  16  to SPI_Periphery.data_send: {status[7:0], rdata[7:0]}
- cfg_regs  output  NUM_REGS*8  flattened register bank; reg i = [8i+7:8i]
- wr_strobe  output  1  one-cycle pulse on every accepted write
- wr_addr  output  6  address of the last accepted write
- frame_err  output  1  one-cycle pulse on a rejected or aborted frame

Behaviour:
- Reset values: cfg_regs=0, data_send=0, wr_strobe=0, wr_addr=0, frame_err=0, status=0, FSM=IDLE, bit counter=0, synchronisers=1 (CS idle high, SCK idle high).
- CS and SCK pass through SYNC_STAGES flops. sck_rise = synced SCK 0->1. cs_low = synced CS == 0.
- Command word: [15]=WR (1 write, 0 read), [14]=parity/ignored, [13:8]=ADDR, [7:0]=WDATA. Word is used as presented on copi_word; no bit reversal.
- FSM:
  - IDLE: on cs_low -> SHIFT; bitcnt=0.
  - SHIFT: on sck_rise, bitcnt++ (5-bit). When bitcnt reaches FRAME_BITS -> GUARD. If CS deasserts first -> IDLE, frame_err pulse, status[5]=1 (abort).
  - GUARD: one clk of settle -> CAPTURE. CS high here -> IDLE with abort, as above.
  - CAPTURE: one clk. Latch copi_word and decode -> WAIT_END.
  - WAIT_END: ignore SCK (readback half of the frame). On synced CS high -> IDLE.
- Decode, in the CAPTURE cycle; effects visible the next clk:
  - Write, ADDR < NUM_REGS: reg[ADDR] <= WDATA; wr_strobe=1 for 1 clk; wr_addr=ADDR.
  - Write, ADDR >= NUM_REGS, including 0x3F: no register change; frame_err pulse; status[7]=1.
  - Read, ADDR < NUM_REGS: rdata <= reg[ADDR].
  - Read, ADDR = 0x3F: rdata <= status, then status[7:5] clear. A reads-status-clears collision resolves with set winning.
  - Read, other ADDR: rdata <= 0x00; status[7]=1; frame_err pulse.
- status = {addr_err, parity_err, abort, frame_cnt[4:0]}. frame_cnt increments on every CAPTURE and wraps 31->0.
- data_send updates only in the cycle after CAPTURE, which is inside WAIT_END, and is otherwise held. SPI_Periphery samples data_send at count==16 of the *next* frame, so a read response is returned one frame late.
- A write and a read never coincide: one command per frame.
- Reset mid-frame: all state returns to reset values immediately. The current frame is lost and no write occurs.
- CS glitch shorter than SYNC_STAGES clks: filtered, no effect.

Optional Feature:
- Macro: SPI_REG_PARITY_EN
- Defined: bit[14] must make the XOR of all 16 word bits equal 1 (odd parity). On mismatch: no write or read update, frame_err pulse, status[6]=1. frame_cnt still increments.
- Undefined: bit[14] ignored. status[6] is tied to 0.

Test Plan:
- Write 0x8255 (WR, addr 2, data 0x55), CS high, then read 0x0200 for two frames -> reg2=0x55; wr_strobe one pulse with wr_addr=2; second frame's data_send[7:0]=0x55.
- Write to addr 0x0A with NUM_REGS=8 -> no cfg change; frame_err pulse; status[7]=1. Next read of 0x3F -> rdata has bit7=1, and status[7] reads 0 afterwards.
- CS raised after 9 SCK edges -> FSM returns to IDLE, no write, frame_err pulse, status[5]=1, frame_cnt unchanged.
- 33 back-to-back frames -> frame_cnt wraps to 1; regs retain their last written values.
- Assert rst_internal low during WAIT_END of a write frame (after CAPTURE) -> cfg_regs=0, data_send=0. The next full frame is decoded normally.
- SPI_REG_PARITY_EN defined: word 0xC255 (parity correct) -> writes reg2=0x55. Word 0x8255 (parity bad) -> no write, status[6]=1.

Source files
------------

// File: rtl/spi_reg_bank_if.sv
// Frame-level link between SPI_Periphery and spi_reg_bank: raw CS/SCK, received command word, readback word.
// Latency: wires only.
// Backpressure: none; the SPI master paces every frame.
interface spi_reg_bank_if;
    logic        spi_cs;
    logic        spi_sck;
    logic [15:0] copi_word;
    logic [15:0] data_send;

    modport master (output spi_cs, spi_sck, copi_word, input data_send);
    modport slave  (input spi_cs, spi_sck, copi_word, output data_send);
endinterface

// File: rtl/spi_reg_bank.sv
// SPI command decoder into an 8-bit config register bank for the buck controller (SPI_REG_PARITY_EN adds odd parity on bit 14).
// Latency: effects land 1 clk after CAPTURE, about SYNC_STAGES+4 clk after the 16th SCK rise; read data returns one frame late.
// Backpressure: none; one command per frame, and extra SCK edges before CS rises are ignored.
module spi_reg_bank #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_internal,
    spi_reg_bank_if.slave         bus,
    output logic [NUM_REGS*8-1:0] cfg_regs,
    output logic                  wr_strobe,
    output logic [5:0]            wr_addr,
    output logic                  frame_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GUARD,
        S_CAPTURE,
        S_WAIT_END
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   cs_filt;
    logic                   sck_prev;
    logic                   cs_low;
    logic                   sck_rise;

    state_t      state;
    logic [4:0]  bitcnt;
    logic [7:0]  status_q;
    logic [7:0]  rdata_q;
    logic [15:0] data_send_q;

    logic        cmd_wr;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        addr_ok;
    logic        parity_ok;
    logic        cap_write;
    logic        cap_err;
    logic [7:0]  rd_mux;
    logic [7:0]  status_nxt;
    logic [7:0]  rdata_nxt;

    // CS only changes once every synchroniser stage agrees, so glitches shorter than the chain are dropped.
    always_ff @(posedge clk or negedge rst_internal) begin
        if (!rst_internal) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            cs_filt  <= 1'b1;
            sck_prev <= 1'b1;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            sck_prev <= sck_sync[SYNC_STAGES-1];
            if (cs_sync == '0) begin
                cs_filt <= 1'b0;
            end else if (&cs_sync) begin
                cs_filt <= 1'b1;
            end
        end
    end

    assign cs_low   = ~cs_filt;
    assign sck_rise = sck_sync[SYNC_STAGES-1] & ~sck_prev;

    assign cmd_wr    = bus.copi_word[15];
    assign cmd_addr  = bus.copi_word[13:8];
    assign cmd_wdata = bus.copi_word[7:0];
    assign addr_ok   = (32'(cmd_addr) < 32'(NUM_REGS));

`ifdef SPI_REG_PARITY_EN
    assign parity_ok = ^bus.copi_word;
`else
    logic unused_parity_bit;
    assign parity_ok         = 1'b1;
    assign unused_parity_bit = bus.copi_word[14];
`endif

    always_comb begin
        rd_mux = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_addr == 6'(i)) rd_mux = cfg_regs[8*i +: 8];
        end
    end

    // Command decode, consumed only in CAPTURE; a status read returns the pre-capture value.
    always_comb begin
        status_nxt      = status_q;
        status_nxt[4:0] = status_q[4:0] + 5'd1;
        rdata_nxt       = rdata_q;
        cap_write       = 1'b0;
        cap_err         = 1'b0;
        if (!parity_ok) begin
            status_nxt[6] = 1'b1;
            cap_err       = 1'b1;
        end else if (cmd_wr) begin
            if (addr_ok) begin
                cap_write = 1'b1;
            end else begin
                status_nxt[7] = 1'b1;
                cap_err       = 1'b1;
            end
        end else if (addr_ok) begin
            rdata_nxt = rd_mux;
        end else if (cmd_addr == 6'h3F) begin
            rdata_nxt       = status_q;
            status_nxt[7:5] = 3'b000;
        end else begin
            rdata_nxt     = 8'h00;
            status_nxt[7] = 1'b1;
            cap_err       = 1'b1;
        end
`ifndef SPI_REG_PARITY_EN
        status_nxt[6] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_internal) begin
        if (!rst_internal) begin
            state       <= S_IDLE;
            bitcnt      <= 5'd0;
            cfg_regs    <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= 6'd0;
            frame_err   <= 1'b0;
            status_q    <= 8'h00;
            rdata_q     <= 8'h00;
            data_send_q <= 16'h0000;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cs_low) begin
                        state  <= S_SHIFT;
                        bitcnt <= 5'd0;
                    end
                end
                S_SHIFT: begin
                    if (!cs_low) begin
                        state       <= S_IDLE;
                        frame_err   <= 1'b1;
                        status_q[5] <= 1'b1;
                    end else if (sck_rise) begin
                        bitcnt <= bitcnt + 5'd1;
                        if (bitcnt == 5'(FRAME_BITS - 1)) state <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (!cs_low) begin
                        state       <= S_IDLE;
                        frame_err   <= 1'b1;
                        status_q[5] <= 1'b1;
                    end else begin
                        state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    state       <= S_WAIT_END;
                    status_q    <= status_nxt;
                    rdata_q     <= rdata_nxt;
                    data_send_q <= {status_nxt, rdata_nxt};
                    frame_err   <= cap_err;
                    if (cap_write) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= cmd_addr;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (cmd_addr == 6'(i)) cfg_regs[8*i +: 8] <= cmd_wdata;
                        end
                    end
                end
                S_WAIT_END: begin
                    if (!cs_low) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_send = data_send_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed and random SPI frames against a frame-level model of the register bank.
module tb_spi_reg_bank;
    localparam int NUM_REGS    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FRAME_BITS  = 16;

    logic                  clk;
    logic                  rst_internal;
    logic [NUM_REGS*8-1:0] cfg_regs;
    logic                  wr_strobe;
    logic [5:0]            wr_addr;
    logic                  frame_err;

    spi_reg_bank_if bus ();

    spi_reg_bank #(
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(SYNC_STAGES),
        .FRAME_BITS (FRAME_BITS)
    ) dut (
        .clk         (clk),
        .rst_internal(rst_internal),
        .bus         (bus.slave),
        .cfg_regs    (cfg_regs),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tot_strobe = 0;
    int tot_err    = 0;
    bit quiet = 0;

    logic [7:0]  m_reg [NUM_REGS];
    logic [7:0]  m_status;
    logic [7:0]  m_rdata;
    logic [15:0] m_dsend;
    logic [5:0]  m_wr_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_REGS*8-1:0] m_cfg_vec();
        logic [NUM_REGS*8-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = m_reg[i];
        return v;
    endfunction

    function automatic logic [15:0] fix(input logic [15:0] w);
        logic [15:0] r;
        r = w;
`ifdef SPI_REG_PARITY_EN
        r[14] = 1'b0;
        if ((^r) == 1'b0) r[14] = 1'b1;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_reg[i] = 8'h00;
        m_status  = 8'h00;
        m_rdata   = 8'h00;
        m_dsend   = 16'h0000;
        m_wr_addr = 6'd0;
    endtask

    // Frame-level effect of one command: expected strobe and error pulse counts come back out.
    task automatic model_frame(input logic [15:0] w, input bit full, output int es, output int ee);
        logic [7:0] st;
        int a;
        bit perr;
        es = 0;
        ee = 0;
        a  = int'(w[13:8]);
        if (!full) begin
            m_status[5] = 1'b1;
            ee = 1;
            return;
        end
`ifdef SPI_REG_PARITY_EN
        perr = ((^w) == 1'b0);
`else
        perr = 1'b0;
`endif
        st = m_status;
        st[4:0] = st[4:0] + 5'd1;
        if (perr) begin
            st[6] = 1'b1;
            ee = 1;
        end else if (w[15]) begin
            if (a < NUM_REGS) begin
                m_reg[a]  = w[7:0];
                m_wr_addr = w[13:8];
                es = 1;
            end else begin
                st[7] = 1'b1;
                ee = 1;
            end
        end else if (a < NUM_REGS) begin
            m_rdata = m_reg[a];
        end else if (a == 63) begin
            m_rdata = m_status;
            st[7:5] = 3'b000;
        end else begin
            m_rdata = 8'h00;
            st[7] = 1'b1;
            ee = 1;
        end
        m_status = st;
        m_dsend  = {m_status, m_rdata};
    endtask

    always @(negedge clk) begin
        if (wr_strobe) tot_strobe++;
        if (frame_err) tot_err++;
    end

    always @(negedge clk) begin
        if (quiet) begin
            chk("ds_track", bus.data_send, m_dsend);
            chk("cfg_track", cfg_regs, m_cfg_vec());
            chk("strobe_idle", wr_strobe, 0);
            chk("err_idle", frame_err, 0);
        end
    end

    task automatic run_frame(input logic [15:0] word, input int nbits, input int extra, input bit rst_mid);
        int s0, e0, exp_s, exp_e;
        quiet = 0;
        s0 = tot_strobe;
        e0 = tot_err;
        bus.copi_word = word;
        @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < nbits + extra; b++) begin
            bus.spi_sck = 1'b0;
            repeat (4) @(negedge clk);
            bus.spi_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        if (rst_mid) begin
            rst_internal = 1'b0;
            @(negedge clk);
            chk("rst_mid_cfg", cfg_regs, 0);
            chk("rst_mid_dsend", bus.data_send, 0);
            chk("rst_mid_strobe", wr_strobe, 0);
            chk("rst_mid_err", frame_err, 0);
            bus.spi_cs = 1'b1;
            repeat (3) @(negedge clk);
            rst_internal = 1'b1;
        end else begin
            bus.spi_cs = 1'b1;
        end
        repeat (6) @(negedge clk);
        model_frame(word, nbits == FRAME_BITS, exp_s, exp_e);
        if (rst_mid) model_reset();
        chk("strobe_count", tot_strobe - s0, exp_s);
        chk("err_count", tot_err - e0, exp_e);
        chk("wr_addr", wr_addr, m_wr_addr);
        quiet = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] w;
        int nb;
        int e0;
        rst_internal  = 1'b0;
        bus.spi_cs    = 1'b1;
        bus.spi_sck   = 1'b1;
        bus.copi_word = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_cfg", cfg_regs, 0);
        chk("reset_dsend", bus.data_send, 0);
        chk("reset_strobe", wr_strobe, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_err", frame_err, 0);
        rst_internal = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(fix(16'h8255), 16, 0, 0);
        chk("wr_reg2", cfg_regs[23:16], 8'h55);
        chk("wr_addr2", wr_addr, 6'd2);
        run_frame(fix(16'h0200), 16, 16, 0);
        run_frame(fix(16'h0200), 16, 16, 0);
        chk("rd_reg2", bus.data_send, 16'h0355);

        run_frame(fix(16'h8A77), 16, 0, 0);
        chk("bad_wr_nochange", cfg_regs, 64'h0000_0000_0055_0000);
        run_frame(fix(16'h3F00), 16, 4, 0);
        chk("rd_status", bus.data_send, 16'h0584);
        run_frame(fix(16'h3F00), 16, 4, 0);
        chk("status_cleared", bus.data_send, 16'h0605);

        run_frame(fix(16'h8166), 9, 0, 0);
        chk("abort_hold", bus.data_send, 16'h0605);
        chk("abort_nowrite", cfg_regs[15:8], 8'h00);
        run_frame(fix(16'h3F00), 16, 0, 0);
        chk("abort_status", bus.data_send, 16'h0726);

        quiet = 0;
        e0 = tot_err;
        @(negedge clk);
        bus.spi_cs = 1'b0;
        repeat (SYNC_STAGES - 1) @(negedge clk);
        bus.spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_err", tot_err - e0, 0);
        chk("glitch_dsend", bus.data_send, 16'h0726);
        run_frame(fix(16'h8199), 16, 0, 0);
        chk("post_glitch_wr", cfg_regs[15:8], 8'h99);

`ifdef SPI_REG_PARITY_EN
        run_frame(16'h8400, 16, 0, 0);
        run_frame(16'hC455, 16, 0, 0);
        chk("par_ok_wr", cfg_regs[39:32], 8'h55);
        run_frame(16'h84AA, 16, 0, 0);
        chk("par_bad_nowr", cfg_regs[39:32], 8'h55);
        run_frame(fix(16'h3F00), 16, 0, 0);
        chk("par_status", bus.data_send[6], 1'b1);
`endif

        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       w[13:8] = 6'h3F;
                1:       w[13:8] = 6'($urandom_range(0, 9));
                default: w[13:8] = 6'($urandom_range(0, NUM_REGS - 1));
            endcase
`ifdef SPI_REG_PARITY_EN
            if ($urandom_range(0, 3) != 0) w = fix(w);
`endif
            nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 15)) : FRAME_BITS;
            run_frame(w, nb, (nb == FRAME_BITS) ? int'($urandom_range(0, 4)) : 0, 0);
        end

        run_frame(fix(16'h8144), 16, 2, 1);
        chk("after_rst_dsend", bus.data_send, 16'h0000);
        run_frame(fix(16'h8333), 16, 0, 0);
        chk("post_rst_wr", cfg_regs[31:24], 8'h33);
        chk("post_rst_only", cfg_regs[15:8], 8'h00);
        for (int i = 1; i < 32; i++) begin
            run_frame(fix({2'b00, 6'(i % NUM_REGS), 8'h00}), 16, 0, 0);
        end
        run_frame(fix(16'h0300), 16, 0, 0);
        chk("wrap_cnt", bus.data_send, 16'h0133);

        quiet = 0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
